// File: rtl/hs_lane_rx_ctrl.sv
// hs_lane_rx_ctrl: receive-side sequencer for one MIPI D-PHY HS data lane.
// Hunts the serial stream for the HS sync byte, then frames 8-bit groups
// into byte strobes and gates the deserializer shift enable.
// Optional feature macro: SYNC_ERR_TOL_EN (accept sync with one bit in error).
module hs_lane_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned HUNT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_en,
  input  logic             datain,
  output logic             deser_en,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             sync_found,
  output logic             sync_err,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q;
  logic [7:0]       sh_q;
  logic [7:0]       sh_d;
  logic [2:0]       bit_cnt_q;
  logic [15:0]      hunt_cnt_q;
  logic [7:0]       byte_out_q;
  logic             byte_valid_q;
  logic             sync_found_q;
  logic             sync_err_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             sync_match;

  localparam logic [15:0]      HUNT_LAST = 16'(HUNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next shift-register value: new bit enters at the top, first bit ends in [0].
  always_comb begin
    sh_d = {datain, sh_q[7:1]};
  end

`ifdef SYNC_ERR_TOL_EN
  logic [7:0] sync_diff;
  logic [3:0] sync_ones;

  // Sync accepted when at most one bit differs from the sync pattern.
  always_comb begin
    sync_diff = sh_d ^ SYNC_BYTE;
    sync_ones = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      sync_ones = sync_ones + {3'b000, sync_diff[i]};
    end
    sync_match = (sync_ones <= 4'd1);
  end
`else
  // Sync accepted only on an exact pattern match.
  always_comb begin
    sync_match = (sh_d == SYNC_BYTE);
  end
`endif

  // Lane sequencer: leaving HS mode overrides every state and drops any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      hunt_cnt_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      sync_err_q   <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      if (!hs_en) begin
        state_q    <= IDLE;
        sh_q       <= '0;
        bit_cnt_q  <= '0;
        hunt_cnt_q <= '0;
        sync_err_q <= 1'b0;
        byte_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            hunt_cnt_q <= '0;
            byte_cnt_q <= '0;
            state_q    <= HUNT;
          end
          HUNT: begin
            sh_q       <= sh_d;
            hunt_cnt_q <= hunt_cnt_q + 16'd1;
            if (sync_match) begin
              state_q      <= DATA;
              sync_found_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else if (hunt_cnt_q == HUNT_LAST) begin
              state_q    <= ERR;
              sync_err_q <= 1'b1;
            end
          end
          DATA: begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_out_q   <= sh_d;
              byte_valid_q <= 1'b1;
              if (byte_cnt_q != '1) begin
                byte_cnt_q <= byte_cnt_q + CNT_ONE;
              end
            end
          end
          ERR: begin
            sync_err_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign deser_en   = (state_q == DATA);
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign sync_found = sync_found_q;
  assign sync_err   = sync_err_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_hs_lane_rx_ctrl.sv
// tb_hs_lane_rx_ctrl: directed bench for hs_lane_rx_ctrl with a queue-based
// reference model of the lane behaviour and per-cycle output comparison.
module tb_hs_lane_rx_ctrl;

  localparam int          CNT_W = 16;
  localparam int          HT    = 64;
  localparam logic [7:0]  SYNC  = 8'hB8;
`ifdef SYNC_ERR_TOL_EN
  localparam int          TOL   = 1;
`else
  localparam int          TOL   = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             hs_en;
  logic             datain;
  logic             deser_en;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             sync_found;
  logic             sync_err;
  logic [CNT_W-1:0] byte_cnt;

  hs_lane_rx_ctrl #(
    .SYNC_BYTE(SYNC),
    .HUNT_TIMEOUT(HT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hs_en(hs_en),
    .datain(datain),
    .deser_en(deser_en),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .sync_found(sync_found),
    .sync_err(sync_err),
    .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_bv     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits seen this burst held in queues, outputs derived from them.
  bit          m_in_burst;
  bit          m_synced;
  bit          m_tout;
  int          m_hunt;
  bit          win[$];
  bit          dq[$];
  logic [7:0]  e_byte;
  bit          e_bv;
  bit          e_sf;
  bit          e_err;
  bit          e_de;
  int unsigned e_cnt;

  function automatic void model_reset();
    m_in_burst = 0; m_synced = 0; m_tout = 0; m_hunt = 0;
    win.delete(); dq.delete();
    e_byte = 8'h00; e_bv = 0; e_sf = 0; e_err = 0; e_de = 0; e_cnt = 0;
  endfunction

  function automatic logic [7:0] window_value();
    logic [7:0] w;
    int n;
    w = 8'h00;
    n = win.size();
    for (int i = 0; i < n; i++) w[8 - n + i] = win[i];
    return w;
  endfunction

  function automatic void model_update(input bit h, input bit d);
    e_bv = 0;
    e_sf = 0;
    if (!h) begin
      m_in_burst = 0; m_synced = 0; m_tout = 0; m_hunt = 0;
      win.delete(); dq.delete();
      e_err = 0; e_cnt = 0;
    end else if (!m_in_burst) begin
      m_in_burst = 1; m_hunt = 0; e_cnt = 0;
      win.delete(); dq.delete();
    end else if (m_tout) begin
      e_err = 1;
    end else if (!m_synced) begin
      win.push_back(d);
      if (win.size() > 8) void'(win.pop_front());
      m_hunt++;
      if ($countones(window_value() ^ SYNC) <= TOL) begin
        m_synced = 1; e_sf = 1; dq.delete();
      end else if (m_hunt == HT) begin
        m_tout = 1; e_err = 1;
      end
    end else begin
      dq.push_back(d);
      if (dq.size() == 8) begin
        for (int i = 0; i < 8; i++) e_byte[i] = dq[i];
        e_bv = 1;
        if (e_cnt < (2 ** CNT_W) - 1) e_cnt++;
        dq.delete();
      end
    end
    e_de = m_in_burst && m_synced;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #2;
    check("deser_en", deser_en, e_de);
    check("byte_out", byte_out, e_byte);
    check("byte_valid", byte_valid, e_bv);
    check("sync_found", sync_found, e_sf);
    check("sync_err", sync_err, e_err);
    check("byte_cnt", byte_cnt, e_cnt);
    if (byte_valid) n_bv++;
  end

  task automatic step(input bit h, input bit d);
    @(negedge clk);
    hs_en  = h;
    datain = d;
    model_update(h, d);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) step(1'b1, b[i]);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  int nb0;

  initial begin
    rst_n = 1'b0; hs_en = 1'b0; datain = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_byte_cnt", byte_cnt, 0);
    check("reset_deser_en", deser_en, 0);
    rst_n = 1'b1;

    // Sync then 0x5A
    step(1'b1, 1'b0);
    send_byte(SYNC);
    settle();
    check("t1_sync_found", sync_found, 1);
    check("t1_deser_en", deser_en, 1);
    nb0 = n_bv;
    send_byte(8'h5A);
    settle();
    check("t1_byte_valid", byte_valid, 1);
    check("t1_byte_out", byte_out, 8'h5A);
    check("t1_byte_cnt", byte_cnt, 1);
    check("t1_strobes", n_bv - nb0, 1);
    step(1'b0, 1'b0);

    // Leading noise then three back-to-back bytes
    step(1'b1, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    send_byte(SYNC);
    settle();
    check("t2_sync_found", sync_found, 1);
    nb0 = n_bv;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    settle();
    check("t2_byte_out", byte_out, 8'h3C);
    check("t2_byte_cnt", byte_cnt, 3);
    check("t2_strobes", n_bv - nb0, 3);
    step(1'b0, 1'b0);

    // Hunt timeout
    nb0 = n_bv;
    step(1'b1, 1'b0);
    repeat (HT - 1) step(1'b1, 1'b0);
    settle();
    check("t3_err_before", sync_err, 0);
    step(1'b1, 1'b0);
    settle();
    check("t3_err_at_65", sync_err, 1);
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    check("t3_no_strobe", n_bv - nb0, 0);
    step(1'b0, 1'b0);
    settle();
    check("t3_err_cleared", sync_err, 0);
    check("t3_deser_off", deser_en, 0);

    // Partial byte dropped, restart clears byte_cnt, exit beats 8th bit
    step(1'b1, 1'b0);
    send_byte(SYNC);
    nb0 = n_bv;
    send_byte(8'hC3);
    repeat (5) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    settle();
    check("t4_one_strobe", n_bv - nb0, 1);
    check("t4_byte_hold", byte_out, 8'hC3);
    step(1'b1, 1'b0);
    send_byte(SYNC);
    settle();
    check("t4_cnt_restart", byte_cnt, 0);
    send_byte(8'h81);
    settle();
    check("t4_cnt_one", byte_cnt, 1);
    check("t4_byte_out", byte_out, 8'h81);
    nb0 = n_bv;
    repeat (7) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    settle();
    check("t4_exit_prio", n_bv - nb0, 0);
    check("t4_exit_hold", byte_out, 8'h81);

    // One-bit-error sync pattern 0xB9
    step(1'b1, 1'b0);
    send_byte(8'hB9);
    repeat (HT - 8) step(1'b1, 1'b0);
    settle();
`ifdef SYNC_ERR_TOL_EN
    check("t5_tol_synced", deser_en, 1);
    check("t5_tol_no_err", sync_err, 0);
`else
    check("t5_no_sync", deser_en, 0);
    check("t5_timeout", sync_err, 1);
`endif
    step(1'b0, 1'b0);

    // Asynchronous reset mid-byte, then a fresh burst
    step(1'b1, 1'b0);
    send_byte(SYNC);
    send_byte(8'h77);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    hs_en = 1'b0;
    model_reset();
    #1;
    check("t6_rst_deser", deser_en, 0);
    check("t6_rst_byte_out", byte_out, 8'h00);
    check("t6_rst_cnt", byte_cnt, 0);
    check("t6_rst_valid", byte_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    send_byte(SYNC);
    send_byte(8'hA5);
    settle();
    check("t6_byte_out", byte_out, 8'hA5);
    check("t6_byte_cnt", byte_cnt, 1);
    step(1'b0, 1'b0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
